// File: rtl/pong_pkg.sv
// pong_pkg: shared position width, default geometry and the ball controller state type.
package pong_pkg;
  localparam int POS_W = 10;
  localparam int CNT_W = 16;
  localparam int MAX_SPEED = 4;
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_BALL_SIZE = 4;
  localparam int DEF_PADDLE_X = 0;
  localparam int DEF_PADDLE_W = 10;
  localparam int DEF_PADDLE_H = 50;
  localparam int DEF_BALL_SPEED = 1;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_SCORE_W = 8;
  typedef enum logic [1:0] {IDLE, SERVE, PLAY, MISS} state_t;
endpackage

// File: rtl/pong_ball_step.sv
// pong_ball_step: one-frame ball move with wall reflection, paddle hit and miss detection.
module pong_ball_step
  import pong_pkg::*;
#(
  parameter int SCREEN_W  = DEF_SCREEN_W,
  parameter int SCREEN_H  = DEF_SCREEN_H,
  parameter int BALL_SIZE = DEF_BALL_SIZE,
  parameter int PADDLE_X  = DEF_PADDLE_X,
  parameter int PADDLE_W  = DEF_PADDLE_W,
  parameter int PADDLE_H  = DEF_PADDLE_H
) (
  input  logic [POS_W-1:0] x,
  input  logic [POS_W-1:0] y,
  input  logic [POS_W-1:0] paddle_y,
  input  logic             dir_x,
  input  logic             dir_y,
  input  logic [POS_W:0]   speed,
  output logic [POS_W-1:0] nx,
  output logic [POS_W-1:0] ny,
  output logic             ndx,
  output logic             ndy,
  output logic             hit,
  output logic             miss
);
  localparam logic [POS_W:0] X_MAX = (POS_W+1)'(SCREEN_W - BALL_SIZE);
  localparam logic [POS_W:0] Y_MAX = (POS_W+1)'(SCREEN_H - BALL_SIZE);
  localparam logic [POS_W:0] FACE  = (POS_W+1)'(PADDLE_X + PADDLE_W);
  localparam logic [POS_W:0] BS    = (POS_W+1)'(BALL_SIZE);
  localparam logic [POS_W:0] PH    = (POS_W+1)'(PADDLE_H);
  logic [POS_W:0] xe, ye, pe, dn, up, rt, lt;
  logic overlap;
  // dir_x/dir_y: 1 = right/down; 11-bit math so sums never wrap past the limits
  always_comb begin
    xe = {1'b0, x};
    ye = {1'b0, y};
    pe = {1'b0, paddle_y};
    dn = ye + speed;
    up = ye - speed;
    rt = xe + speed;
    lt = xe - speed;
    overlap = (ye + BS > pe) && (ye < pe + PH);
    hit = !dir_x && xe > FACE && lt <= FACE && overlap;
    miss = !dir_x && !hit && xe <= speed;
    nx = dir_x ? (rt >= X_MAX ? POS_W'(X_MAX) : POS_W'(rt)) :
         hit ? POS_W'(FACE) : miss ? '0 : POS_W'(lt);
    ndx = dir_x ? rt < X_MAX : hit;
    ny = dir_y ? (dn >= Y_MAX ? POS_W'(Y_MAX) : POS_W'(dn)) :
         (ye <= speed ? '0 : POS_W'(up));
    ndy = dir_y ? dn < Y_MAX : ye <= speed;
  end
endmodule

// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl: per-frame ball sequencer updated at the start of vertical blank.
// Define PONG_SPEEDUP_EN to raise ball speed by one every 4th paddle hit (cap 4).
module pong_ball_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_W     = DEF_SCREEN_W,
  parameter int SCREEN_H     = DEF_SCREEN_H,
  parameter int BALL_SIZE    = DEF_BALL_SIZE,
  parameter int PADDLE_X     = DEF_PADDLE_X,
  parameter int PADDLE_W     = DEF_PADDLE_W,
  parameter int PADDLE_H     = DEF_PADDLE_H,
  parameter int BALL_SPEED   = DEF_BALL_SPEED,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int SCORE_W      = DEF_SCORE_W
) (
  input  logic               pixel_clk,
  input  logic               reset,
  input  logic               V_visible,
  input  logic [POS_W-1:0]   paddle_Y_location,
  input  logic               serve_btn,
  output logic [POS_W-1:0]   ball_X_location,
  output logic [POS_W-1:0]   ball_Y_location,
  output logic               ball_visible,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [SCORE_W-1:0] score
);
  localparam logic [POS_W-1:0] X0  = POS_W'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [POS_W-1:0] Y0  = POS_W'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [CNT_W-1:0] CD0 = CNT_W'(SERVE_FRAMES - 1);
  state_t state;
  logic prev, tick, dir_x, dir_y, serve_toggle;
  logic [CNT_W-1:0] countdown;
  logic [POS_W:0] speed;
  logic [POS_W-1:0] nx, ny;
  logic ndx, ndy, hit, miss;
  assign tick = prev & ~V_visible;
  pong_ball_step #(
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .BALL_SIZE(BALL_SIZE),
    .PADDLE_X(PADDLE_X), .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H)
  ) u_step (
    .x(ball_X_location), .y(ball_Y_location), .paddle_y(paddle_Y_location),
    .dir_x(dir_x), .dir_y(dir_y), .speed(speed),
    .nx(nx), .ny(ny), .ndx(ndx), .ndy(ndy), .hit(hit), .miss(miss)
  );
`ifdef PONG_SPEEDUP_EN
  logic [1:0] hit_cnt;
  always_ff @(posedge pixel_clk)
    if (reset || state == IDLE) begin
      speed <= (POS_W+1)'(BALL_SPEED);
      hit_cnt <= '0;
    end else if (tick && state == PLAY && hit) begin
      hit_cnt <= hit_cnt + 1'b1;
      if (hit_cnt == 2'd3 && speed < (POS_W+1)'(MAX_SPEED)) speed <= speed + 1'b1;
    end
`else
  assign speed = (POS_W+1)'(BALL_SPEED);
`endif
  always_ff @(posedge pixel_clk) begin
    prev <= V_visible;
    if (reset) begin
      state <= IDLE;
      ball_X_location <= X0;
      ball_Y_location <= Y0;
      dir_x <= 1'b1;
      dir_y <= 1'b1;
      score <= '0;
      ball_visible <= 1'b1;
      hit_pulse <= 1'b0;
      miss_pulse <= 1'b0;
      countdown <= '0;
      serve_toggle <= 1'b0;
    end else begin
      hit_pulse <= 1'b0;
      miss_pulse <= 1'b0;
      if (tick)
        case (state)
          IDLE: if (serve_btn) begin
            countdown <= CD0;
            dir_x <= 1'b1;
            dir_y <= ~serve_toggle;
            serve_toggle <= ~serve_toggle;
            state <= SERVE;
          end
          SERVE: if (countdown == '0) state <= PLAY; else countdown <= countdown - 1'b1;
          PLAY: begin
            ball_X_location <= nx;
            ball_Y_location <= ny;
            dir_x <= ndx;
            dir_y <= ndy;
            hit_pulse <= hit;
            miss_pulse <= miss;
            if (hit && !(&score)) score <= score + 1'b1;
            if (miss) begin
              state <= MISS;
              ball_visible <= 1'b0;
              countdown <= CD0;
            end
          end
          MISS: if (countdown == '0) begin
            ball_X_location <= X0;
            ball_Y_location <= Y0;
            ball_visible <= 1'b1;
            state <= IDLE;
          end else countdown <= countdown - 1'b1;
          default: state <= IDLE;
        endcase
    end
  end
endmodule

// File: tb/tb_pong_ball_ctrl.sv
// tb_pong_ball_ctrl: random serve/paddle stimulus checked against a frame-level ball model.
module tb_pong_ball_ctrl;
  localparam int W = 64, H = 48, B = 4, PX = 0, PW = 10, PH = 8, SP = 1, SF = 2;
  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_MISS = 3;
  logic pixel_clk = 0, reset = 1, V_visible = 0, serve_btn = 0;
  logic [9:0] paddle_Y_location = '0;
  logic [9:0] ball_X_location, ball_Y_location;
  logic ball_visible, hit_pulse, miss_pulse;
  logic [7:0] score;
  int checks = 0, errors = 0, hits = 0, misses = 0;
  int mx, my, mdx, mdy, mode, mcd, mtog, mscore, mvis, mhit, mmiss, py;

  always #5 pixel_clk = ~pixel_clk;

  pong_ball_ctrl #(
    .SCREEN_W(W), .SCREEN_H(H), .BALL_SIZE(B), .PADDLE_X(PX), .PADDLE_W(PW),
    .PADDLE_H(PH), .BALL_SPEED(SP), .SERVE_FRAMES(SF), .SCORE_W(8)
  ) dut (
    .pixel_clk(pixel_clk), .reset(reset), .V_visible(V_visible),
    .paddle_Y_location(paddle_Y_location), .serve_btn(serve_btn),
    .ball_X_location(ball_X_location), .ball_Y_location(ball_Y_location),
    .ball_visible(ball_visible), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .score(score)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    mx = (W - B) / 2; my = (H - B) / 2; mdx = 1; mdy = 1;
    mode = M_IDLE; mcd = 0; mtog = 0; mscore = 0; mvis = 1; mhit = 0; mmiss = 0;
  endfunction

  function automatic void model_tick(input int srv, input int pad);
    int nx, ny, face;
    mhit = 0; mmiss = 0;
    face = PX + PW;
    case (mode)
      M_IDLE: if (srv != 0) begin
        mcd = SF - 1; mdx = 1; mdy = (mtog != 0) ? -1 : 1; mtog = 1 - mtog; mode = M_SERVE;
      end
      M_SERVE: if (mcd == 0) mode = M_PLAY; else mcd--;
      M_PLAY: begin
        ny = my + mdy * SP;
        if (ny >= H - B) begin ny = H - B; mdy = -1; end
        else if (ny <= 0) begin ny = 0; mdy = 1; end
        if (mdx > 0) begin
          nx = mx + SP;
          if (nx >= W - B) begin nx = W - B; mdx = -1; end
        end else if (mx > face && mx - SP <= face && my + B > pad && my < pad + PH) begin
          nx = face; mdx = 1; mhit = 1;
          if (mscore < 255) mscore++;
        end else if (mx - SP <= 0) begin
          nx = 0; mmiss = 1; mode = M_MISS; mvis = 0; mcd = SF - 1;
        end else nx = mx - SP;
        mx = nx; my = ny;
      end
      default: if (mcd == 0) begin
        mx = (W - B) / 2; my = (H - B) / 2; mvis = 1; mode = M_IDLE;
      end else mcd--;
    endcase
  endfunction

  task automatic compare_all();
    check("ball_x", int'(ball_X_location), mx);
    check("ball_y", int'(ball_Y_location), my);
    check("ball_visible", int'(ball_visible), mvis);
    check("hit_pulse", int'(hit_pulse), mhit);
    check("miss_pulse", int'(miss_pulse), mmiss);
    check("score", int'(score), mscore);
    @(negedge pixel_clk);
    check("hit_pulse_end", int'(hit_pulse), 0);
    check("miss_pulse_end", int'(miss_pulse), 0);
  endtask

  // one frame: visible, then fall into blank; rst asserts reset on the tick cycle
  task automatic frame(input int srv, input int pad, input bit rst);
    @(negedge pixel_clk);
    V_visible = 1; serve_btn = srv[0]; paddle_Y_location = 10'(pad);
    @(negedge pixel_clk);
    V_visible = 0; reset = rst;
    @(negedge pixel_clk);
    reset = 0; serve_btn = 0;
    if (rst) model_reset(); else model_tick(srv, pad);
    hits += mhit; misses += mmiss;
    compare_all();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge pixel_clk);
    frame(1, 0, 1'b1);
    check("reset_x", int'(ball_X_location), 30);
    check("reset_y", int'(ball_Y_location), 22);
    frame(1, 20, 1'b0);
    frame(0, 20, 1'b0);
    frame(0, 20, 1'b0);
    frame(0, 20, 1'b0);
    check("first_step_x", int'(ball_X_location), 31);
    check("first_step_y", int'(ball_Y_location), 23);
    for (int i = 0; i < 1500; i++) begin
      if (mode == M_PLAY && mdx < 0 && $urandom_range(0, 3) != 0) begin
        py = my - int'($urandom_range(0, 9));
        if (py < 0) py = 0;
      end else py = int'($urandom_range(0, H - 1));
      frame(($urandom_range(0, 3) == 0) ? 1 : 0, py, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end
    while (mode != M_PLAY) frame(1, 0, 1'b0);
    frame(0, 0, 1'b1);
    check("mid_play_reset_x", int'(ball_X_location), 30);
    check("saw_hits", int'(hits > 0), 1);
    check("saw_misses", int'(misses > 0), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
